// File: rtl/fechadura_pkg.sv
// fechadura_pkg: shared types, key codes and default configuration of the lock
package fechadura_pkg;

    typedef struct packed {
        logic [19:0][3:0] digits;
    } senhaPac_t;

    typedef struct packed {
        logic [3:0] BCD5;
        logic [3:0] BCD4;
        logic [3:0] BCD3;
        logic [3:0] BCD2;
        logic [3:0] BCD1;
        logic [3:0] BCD0;
    } bcdPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [6:0] bip_time;
        logic [6:0] tranca_aut_time;
        senhaPac_t  master_pin;
        senhaPac_t  senha_1;
        senhaPac_t  senha_2;
        senhaPac_t  senha_3;
        senhaPac_t  senha_4;
    } setupPac_t;

    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_HASH  = 4'hB;
    localparam logic [3:0] KEY_EMPTY = 4'hF;

    localparam senhaPac_t PIN_EMPTY   = senhaPac_t'({20{4'hF}});
    localparam senhaPac_t PIN_DEFAULT = senhaPac_t'({{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4});
    localparam bcdPac_t   BCD_BLANK   = bcdPac_t'({6{4'hF}});

    localparam setupPac_t SETUP_DEFAULT = '{
        bip_status:      1'b1,
        bip_time:        7'd5,
        tranca_aut_time: 7'd5,
        master_pin:      PIN_DEFAULT,
        senha_1:         PIN_EMPTY,
        senha_2:         PIN_EMPTY,
        senha_3:         PIN_EMPTY,
        senha_4:         PIN_EMPTY
    };

    // two BCD digits {tens, units} of a value below 100
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/setup_value_check.sv
// setup_value_check: parses an entered value into digit count, decimal flag and binary value
module setup_value_check
    import fechadura_pkg::*;
(
    input  senhaPac_t  value,
    output logic [4:0] count,
    output logic       all_dec,
    output logic [6:0] bin
);

    logic run;

    // count the contiguous non-empty digits from the newest one and check they are all 0-9
    always_comb begin
        count   = '0;
        all_dec = 1'b1;
        run     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run = run && (value.digits[i] != KEY_EMPTY);
            if (run) begin
                count   = count + 5'd1;
                all_dec = all_dec && (value.digits[i] <= 4'd9);
            end
        end
        bin = 7'(value.digits[0]) + ((count > 5'd1) ? 7'(value.digits[1]) * 7'd10 : 7'd0);
    end

endmodule

// File: rtl/setup.sv
// setup: configuration-mode controller of the lock (authenticate, edit 8 items, commit)
module setup
    import fechadura_pkg::*;
#(
    parameter int NUM_ITEMS = 8,
    parameter int MIN_TIME  = 5,
    parameter int MAX_TIME  = 60,
    parameter int MIN_PIN   = 4,
    parameter int MAX_PIN   = 12
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      setup_on,
    input  senhaPac_t digitos_value,
    input  logic      digitos_valid,
    output logic      display_en,
    output bcdPac_t   bcd_pac,
    output setupPac_t data_setup_new,
    output logic      data_setup_ok
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_AUTH   = 2'd1;
    localparam logic [1:0] S_CFG    = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] idx_q, idx_d;
    setupPac_t  work_q, work_d, cfg_q, cfg_d;
    logic       ok_q, ok_d, disp_q, disp_d;
    bcdPac_t    bcd_q, bcd_d;

    senhaPac_t  entered;
    logic [4:0] cnt;
    logic       all_dec;
    logic [6:0] bin;
    logic       star, hash, pin_ok, time_ok;

    assign entered = senhaPac_t'({KEY_EMPTY, digitos_value.digits[19:1]});
    assign star    = digitos_valid && (digitos_value.digits[0] == KEY_STAR);
    assign hash    = digitos_valid && (digitos_value.digits[0] == KEY_HASH);
    assign pin_ok  = all_dec && (cnt >= 5'(MIN_PIN)) && (cnt <= 5'(MAX_PIN));
    assign time_ok = all_dec && (cnt != 5'd0) && (cnt <= 5'd2) &&
                     (bin >= 7'(MIN_TIME)) && (bin <= 7'(MAX_TIME));

    setup_value_check u_check (
        .value   (entered),
        .count   (cnt),
        .all_dec (all_dec),
        .bin     (bin)
    );

    // mode sequencing, item editing on the working copy, and commit on the last item
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        work_d  = work_q;
        cfg_d   = cfg_q;
        ok_d    = 1'b0;
        disp_d  = disp_q;
        case (state_q)
            S_IDLE: if (setup_on) begin
                state_d = S_AUTH;
                work_d  = cfg_q;
                disp_d  = 1'b1;
            end
            S_AUTH: if (star && entered == work_q.master_pin) begin
                state_d = S_CFG;
                idx_d   = 4'd1;
            end else if (star || hash) begin
                state_d = S_IDLE;
                disp_d  = 1'b0;
            end
            S_CFG: if (hash) begin
                state_d = S_IDLE;
                disp_d  = 1'b0;
            end else if (star) begin
                case (idx_q)
                    4'd1: if (cnt == 5'd1 && entered.digits[0] <= 4'd1) work_d.bip_status = entered.digits[0][0];
                    4'd2: if (time_ok) work_d.bip_time = bin;
                    4'd3: if (time_ok) work_d.tranca_aut_time = bin;
                    4'd4: if (pin_ok) work_d.master_pin = entered;
                    4'd5: if (pin_ok) work_d.senha_1 = entered;
                    4'd6: if (pin_ok) work_d.senha_2 = entered;
                    4'd7: if (pin_ok) work_d.senha_3 = entered;
                    4'd8: if (pin_ok) work_d.senha_4 = entered;
                    default: ;
                endcase
                if (idx_q == 4'(NUM_ITEMS)) begin
                    state_d = S_COMMIT;
                    cfg_d   = work_d;
                    ok_d    = 1'b1;
                    disp_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // display contents follow the next state so they change with the edge that consumes the key
    always_comb begin
        bcd_d = BCD_BLANK;
        if (state_d == S_AUTH) begin
            bcd_d.BCD5 = 4'd0;
        end else if (state_d == S_CFG) begin
            bcd_d.BCD5 = idx_d;
            if (idx_d == 4'd1) bcd_d.BCD0 = {3'b000, work_d.bip_status};
            if (idx_d == 4'd2) {bcd_d.BCD1, bcd_d.BCD0} = to_bcd(work_d.bip_time);
            if (idx_d == 4'd3) {bcd_d.BCD1, bcd_d.BCD0} = to_bcd(work_d.tranca_aut_time);
        end
    end

    // state and output registers with synchronous reset to the default configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            work_q  <= SETUP_DEFAULT;
            cfg_q   <= SETUP_DEFAULT;
            ok_q    <= 1'b0;
            disp_q  <= 1'b0;
            bcd_q   <= BCD_BLANK;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            cfg_q   <= cfg_d;
            ok_q    <= ok_d;
            disp_q  <= disp_d;
            bcd_q   <= bcd_d;
        end
    end

    assign display_en     = disp_q;
    assign bcd_pac        = bcd_q;
    assign data_setup_new = cfg_q;
    assign data_setup_ok  = ok_q;

endmodule

// File: tb/tb_setup.sv
// tb_setup: directed scoreboard bench for the setup controller
module tb_setup;
    import fechadura_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      setup_on = 1'b0;
    senhaPac_t digitos_value;
    logic      digitos_valid = 1'b0;
    logic      display_en;
    bcdPac_t   bcd_pac;
    setupPac_t data_setup_new;
    logic      data_setup_ok;

    int total = 0;
    int bad = 0;
    senhaPac_t kb;
    setupPac_t def, model;
    setupPac_t exp_q[$];

    setup dut (
        .clk            (clk),
        .rst            (rst),
        .setup_on       (setup_on),
        .digitos_value  (digitos_value),
        .digitos_valid  (digitos_valid),
        .display_en     (display_en),
        .bcd_pac        (bcd_pac),
        .data_setup_new (data_setup_new),
        .data_setup_ok  (data_setup_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        kb.digits = {kb.digits[18:0], k};
        @(negedge clk);
        digitos_value = kb;
        digitos_valid = 1'b1;
        @(negedge clk);
        digitos_valid = 1'b0;
        if (k == 4'hA || k == 4'hB) kb.digits = {20{4'hF}};
    endtask

    task automatic enter_setup();
        @(negedge clk);
        setup_on = 1'b1;
        repeat (2) @(negedge clk);
        setup_on = 1'b0;
    endtask

    task automatic auth_ok();
        enter_setup();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    endtask

    // scoreboard monitor: every commit pulse must match the oldest expected configuration
    initial begin
        setupPac_t e;
        forever begin
            @(negedge clk);
            if (!rst && data_setup_ok) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_commit act=%0h exp=none", data_setup_new);
                end else begin
                    e = exp_q.pop_front();
                    if (data_setup_new !== e) begin
                        bad++;
                        $display("FAIL commit_cfg act=%0h exp=%0h", data_setup_new, e);
                    end
                end
            end
        end
    end

    initial begin
        kb.digits = {20{4'hF}};
        digitos_value = kb;
        def = '0;
        def.bip_status = 1'b1;
        def.bip_time = 7'd5;
        def.tranca_aut_time = 7'd5;
        def.master_pin.digits = {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4};
        def.senha_1.digits = {20{4'hF}};
        def.senha_2.digits = {20{4'hF}};
        def.senha_3.digits = {20{4'hF}};
        def.senha_4.digits = {20{4'hF}};
        model = def;

        repeat (5000) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_disp", 512'(display_en), 512'(0));
        chk("rst_ok", 512'(data_setup_ok), 512'(0));
        chk("rst_bcd", 512'(bcd_pac), 512'(24'hFFFFFF));
        chk("rst_cfg", 512'(data_setup_new), 512'(def));

        enter_setup();
        chk("auth_disp", 512'(display_en), 512'(1));
        chk("auth_bcd", 512'(bcd_pac), 512'(24'h0FFFFF));
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
        chk("cfg_disp", 512'(display_en), 512'(1));
        chk("cfg_bcd_idx1", 512'(bcd_pac), 512'(24'h1FFFF1));

        for (int i = 1; i <= 8; i++) begin
            chk("walk_idx", 512'(bcd_pac.BCD5), 512'(i));
            if (i == 2) chk("walk_bip_time", 512'({bcd_pac.BCD1, bcd_pac.BCD0}), 512'(8'h05));
            if (i == 4) chk("walk_pin_hidden", 512'(bcd_pac[19:0]), 512'(20'hFFFFF));
            if (i == 8) exp_q.push_back(model);
            press(4'hA);
        end
        chk("walk_exit_disp", 512'(display_en), 512'(0));
        chk("walk_exit_bcd", 512'(bcd_pac), 512'(24'hFFFFFF));
        @(negedge clk);
        chk("ok_one_cycle", 512'(data_setup_ok), 512'(0));
        press(4'hA);
        repeat (2) @(negedge clk);
        chk("stray_disp", 512'(display_en), 512'(0));
        chk("walk_cfg_same", 512'(data_setup_new), 512'(def));

        enter_setup();
        press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'hA);
        chk("badpin_disp", 512'(display_en), 512'(0));
        chk("badpin_bcd", 512'(bcd_pac), 512'(24'hFFFFFF));
        repeat (3) @(negedge clk);
        chk("badpin_cfg", 512'(data_setup_new), 512'(model));

        auth_ok();
        press(4'hA);
        press(4'h3); press(4'h0); press(4'hA);
        chk("t2_idx3", 512'(bcd_pac), 512'(24'h3FFF05));
        press(4'h9); press(4'h9); press(4'hA);
        chk("t3_idx4", 512'(bcd_pac.BCD5), 512'(4));
        model.bip_time = 7'd30;
        for (int i = 4; i <= 8; i++) begin
            if (i == 8) exp_q.push_back(model);
            press(4'hA);
        end
        @(negedge clk);
        chk("t2_bip_time", 512'(data_setup_new.bip_time), 512'(30));
        chk("t3_tranca", 512'(data_setup_new.tranca_aut_time), 512'(5));

        auth_ok();
        press(4'hA); press(4'hA); press(4'hA);
        press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hA);
        press(4'hA);
        chk("abort_idx6", 512'(bcd_pac.BCD5), 512'(6));
        press(4'hB);
        chk("abort_disp", 512'(display_en), 512'(0));
        repeat (3) @(negedge clk);
        chk("abort_pin", 512'(data_setup_new.master_pin), 512'(def.master_pin));
        chk("abort_cfg", 512'(data_setup_new), 512'(model));

        auth_ok();
        press(4'h0); press(4'hA);
        press(4'h6); press(4'h0); press(4'hA);
        press(4'h4); press(4'hA);
        chk("t3_min_keep", 512'(bcd_pac), 512'(24'h4FFFFF));
        press(4'h1); press(4'h2); press(4'h3); press(4'hA);
        for (int i = 0; i < 12; i++) press(4'((i + 1) % 10));
        press(4'hA);
        model.bip_status = 1'b0;
        model.bip_time = 7'd60;
        model.senha_1.digits = {{8{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                4'h7, 4'h8, 4'h9, 4'h0, 4'h1, 4'h2};
        press(4'hA); press(4'hA);
        exp_q.push_back(model);
        press(4'hA);
        @(negedge clk);
        chk("edge_senha1", 512'(data_setup_new.senha_1), 512'(model.senha_1));

        auth_ok();
        press(4'hA);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model = def;
        chk("midrst_disp", 512'(display_en), 512'(0));
        chk("midrst_cfg", 512'(data_setup_new), 512'(def));
        press(4'hA);
        repeat (3) @(negedge clk);
        chk("queue_empty", 512'(exp_q.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
